// File: rtl/axi4_master_pkg.sv
// Shared definitions for the single-beat AXI4 master bridge: FSM state encoding,
// AXI channel constants and the watchdog counter sizing helper.
package axi4_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RESP
    } state_t;

    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Watchdog counter is 8 bits wide unless the limit needs more, capped at 16.
    function automatic int unsigned wd_width(input int unsigned limit);
        return ($clog2(limit + 1) <= 8) ? 8 : 16;
    endfunction

endpackage

// File: rtl/axi4_resp_watchdog.sv
// Response-phase watchdog for axi4_simple_master; only built with AXI_MASTER_TIMEOUT_EN.
// Counts cycles while start is high and flags expired on the LIMIT-th cycle.
`ifdef AXI_MASTER_TIMEOUT_EN
module axi4_resp_watchdog
    import axi4_master_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = wd_width(LIMIT);

    logic [CW-1:0] count;

    assign expired = start && (count == CW'(LIMIT - 1));

    always_ff @(posedge ACLK) begin
        if (!ARESETN || clear) begin
            count <= '0;
        end else if (start && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/axi4_simple_master.sv
// Single-beat AXI4 master: one command in, one len-0 INCR transaction out, one response back.
// Optional response watchdog and sticky err_timeout output under AXI_MASTER_TIMEOUT_EN.
module axi4_simple_master
    import axi4_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
`ifdef AXI_MASTER_TIMEOUT_EN
    output logic                      err_timeout,
`endif

    output logic [ADDR_WIDTH-1:0]     M_AXI_awaddr,
    output logic [7:0]                M_AXI_awlen,
    output logic [2:0]                M_AXI_awsize,
    output logic [1:0]                M_AXI_awburst,
    output logic                      M_AXI_awlock,
    output logic [3:0]                M_AXI_awcache,
    output logic [2:0]                M_AXI_awprot,
    output logic [3:0]                M_AXI_awregion,
    output logic [3:0]                M_AXI_awqos,
    output logic                      M_AXI_awvalid,
    input  logic                      M_AXI_awready,

    output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
    output logic                      M_AXI_wlast,
    output logic                      M_AXI_wvalid,
    input  logic                      M_AXI_wready,

    input  logic [1:0]                M_AXI_bresp,
    input  logic                      M_AXI_bvalid,
    output logic                      M_AXI_bready,

    output logic [ADDR_WIDTH-1:0]     M_AXI_araddr,
    output logic [7:0]                M_AXI_arlen,
    output logic [2:0]                M_AXI_arsize,
    output logic [1:0]                M_AXI_arburst,
    output logic                      M_AXI_arlock,
    output logic [3:0]                M_AXI_arcache,
    output logic [2:0]                M_AXI_arprot,
    output logic [3:0]                M_AXI_arregion,
    output logic [3:0]                M_AXI_arqos,
    output logic                      M_AXI_arvalid,
    input  logic                      M_AXI_arready,

    input  logic [DATA_WIDTH-1:0]     M_AXI_rdata,
    input  logic [1:0]                M_AXI_rresp,
    input  logic                      M_AXI_rlast,
    input  logic                      M_AXI_rvalid,
    output logic                      M_AXI_rready
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    state_t state;
    logic   wd_expired;

    assign M_AXI_awlen    = 8'd0;
    assign M_AXI_awsize   = SIZE_4B;
    assign M_AXI_awburst  = BURST_INCR;
    assign M_AXI_awlock   = 1'b0;
    assign M_AXI_awcache  = 4'd0;
    assign M_AXI_awprot   = 3'd0;
    assign M_AXI_awregion = 4'd0;
    assign M_AXI_awqos    = 4'd0;
    assign M_AXI_wlast    = 1'b1;

    assign M_AXI_arlen    = 8'd0;
    assign M_AXI_arsize   = SIZE_4B;
    assign M_AXI_arburst  = BURST_INCR;
    assign M_AXI_arlock   = 1'b0;
    assign M_AXI_arcache  = 4'd0;
    assign M_AXI_arprot   = 3'd0;
    assign M_AXI_arregion = 4'd0;
    assign M_AXI_arqos    = 4'd0;

    // Single-beat bursts make rlast redundant; TIMEOUT_CYCLES only matters with the watchdog.
    logic unused_sink;
    assign unused_sink = &{1'b0, M_AXI_rlast, TIMEOUT_CYCLES[0]};

`ifdef AXI_MASTER_TIMEOUT_EN
    logic wd_start;
    logic wd_clear;

    assign wd_start = (state == WR_RESP) || (state == RD_DATA);
    assign wd_clear = !wd_start;

    axi4_resp_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .start   (wd_start),
        .clear   (wd_clear),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            M_AXI_awaddr  <= '0;
            M_AXI_awvalid <= 1'b0;
            M_AXI_wdata   <= '0;
            M_AXI_wstrb   <= '0;
            M_AXI_wvalid  <= 1'b0;
            M_AXI_bready  <= 1'b0;
            M_AXI_araddr  <= '0;
            M_AXI_arvalid <= 1'b0;
            M_AXI_rready  <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            err_timeout   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            M_AXI_awaddr  <= cmd_addr & WORD_MASK;
                            M_AXI_wdata   <= cmd_wdata;
                            M_AXI_wstrb   <= cmd_wstrb;
                            M_AXI_awvalid <= 1'b1;
                            M_AXI_wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            M_AXI_araddr  <= cmd_addr & WORD_MASK;
                            M_AXI_arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end

                // A deasserted valid here means that channel already handshook.
                WR_REQ: begin
                    if (M_AXI_awready) M_AXI_awvalid <= 1'b0;
                    if (M_AXI_wready)  M_AXI_wvalid  <= 1'b0;
                    if ((!M_AXI_awvalid || M_AXI_awready) &&
                        (!M_AXI_wvalid  || M_AXI_wready)) begin
                        M_AXI_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (M_AXI_bvalid) begin
                        rsp_resp     <= M_AXI_bresp;
                        rsp_rdata    <= '0;
                        M_AXI_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else if (wd_expired) begin
                        rsp_resp     <= RESP_DECERR;
                        rsp_rdata    <= '0;
                        M_AXI_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
`ifdef AXI_MASTER_TIMEOUT_EN
                        err_timeout  <= 1'b1;
`endif
                        state        <= RESP;
                    end
                end

                RD_REQ: begin
                    if (M_AXI_arready) begin
                        M_AXI_arvalid <= 1'b0;
                        M_AXI_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (M_AXI_rvalid) begin
                        rsp_rdata    <= M_AXI_rdata;
                        rsp_resp     <= M_AXI_rresp;
                        M_AXI_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else if (wd_expired) begin
                        rsp_resp     <= RESP_DECERR;
                        rsp_rdata    <= '0;
                        M_AXI_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
`ifdef AXI_MASTER_TIMEOUT_EN
                        err_timeout  <= 1'b1;
`endif
                        state        <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_simple_master.sv
// Self-checking bench for axi4_simple_master: behavioural AXI slave, word-array reference
// model, directed scenarios plus randomized traffic; timeout scenario with AXI_MASTER_TIMEOUT_EN.
module tb_axi4_simple_master;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        err_timeout;

    logic [31:0] M_AXI_awaddr, M_AXI_araddr, M_AXI_wdata;
    logic [7:0]  M_AXI_awlen, M_AXI_arlen;
    logic [2:0]  M_AXI_awsize, M_AXI_arsize, M_AXI_awprot, M_AXI_arprot;
    logic [1:0]  M_AXI_awburst, M_AXI_arburst;
    logic        M_AXI_awlock, M_AXI_arlock;
    logic [3:0]  M_AXI_awcache, M_AXI_arcache, M_AXI_awregion, M_AXI_arregion;
    logic [3:0]  M_AXI_awqos, M_AXI_arqos, M_AXI_wstrb;
    logic        M_AXI_awvalid, M_AXI_awready = 1'b0;
    logic        M_AXI_wlast, M_AXI_wvalid, M_AXI_wready = 1'b0;
    logic [1:0]  M_AXI_bresp = '0;
    logic        M_AXI_bvalid = 1'b0, M_AXI_bready;
    logic        M_AXI_arvalid, M_AXI_arready = 1'b0;
    logic [31:0] M_AXI_rdata = '0;
    logic [1:0]  M_AXI_rresp = '0;
    logic        M_AXI_rlast = 1'b0, M_AXI_rvalid = 1'b0, M_AXI_rready;

    axi4_simple_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
`ifdef AXI_MASTER_TIMEOUT_EN
        , .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .ACLK (ACLK), .ARESETN (ARESETN),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata), .rsp_resp (rsp_resp),
`ifdef AXI_MASTER_TIMEOUT_EN
        .err_timeout (err_timeout),
`endif
        .M_AXI_awaddr (M_AXI_awaddr), .M_AXI_awlen (M_AXI_awlen), .M_AXI_awsize (M_AXI_awsize),
        .M_AXI_awburst (M_AXI_awburst), .M_AXI_awlock (M_AXI_awlock), .M_AXI_awcache (M_AXI_awcache),
        .M_AXI_awprot (M_AXI_awprot), .M_AXI_awregion (M_AXI_awregion), .M_AXI_awqos (M_AXI_awqos),
        .M_AXI_awvalid (M_AXI_awvalid), .M_AXI_awready (M_AXI_awready),
        .M_AXI_wdata (M_AXI_wdata), .M_AXI_wstrb (M_AXI_wstrb), .M_AXI_wlast (M_AXI_wlast),
        .M_AXI_wvalid (M_AXI_wvalid), .M_AXI_wready (M_AXI_wready),
        .M_AXI_bresp (M_AXI_bresp), .M_AXI_bvalid (M_AXI_bvalid), .M_AXI_bready (M_AXI_bready),
        .M_AXI_araddr (M_AXI_araddr), .M_AXI_arlen (M_AXI_arlen), .M_AXI_arsize (M_AXI_arsize),
        .M_AXI_arburst (M_AXI_arburst), .M_AXI_arlock (M_AXI_arlock), .M_AXI_arcache (M_AXI_arcache),
        .M_AXI_arprot (M_AXI_arprot), .M_AXI_arregion (M_AXI_arregion), .M_AXI_arqos (M_AXI_arqos),
        .M_AXI_arvalid (M_AXI_arvalid), .M_AXI_arready (M_AXI_arready),
        .M_AXI_rdata (M_AXI_rdata), .M_AXI_rresp (M_AXI_rresp), .M_AXI_rlast (M_AXI_rlast),
        .M_AXI_rvalid (M_AXI_rvalid), .M_AXI_rready (M_AXI_rready)
    );

`ifndef AXI_MASTER_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    // ---------------- behavioural slave (acts on negedges) ----------------
    int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit          b_never = 1'b0;
    logic [31:0] slave_mem [256];
    logic [31:0] last_awaddr = '0;

    initial begin : slave
        bit          aw_got, w_got, b_pend, r_pend;
        bit          aw_fire, w_fire, b_fire, ar_fire, r_fire;
        int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, idx;
        logic [31:0] aw_a, w_d, ar_a, r_d;
        logic [3:0]  w_s;
        logic [1:0]  b_r, r_r;
        for (int i = 0; i < 256; i++) slave_mem[i] = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                {aw_got, w_got, b_pend, r_pend} = '0;
                {aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
                {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
                M_AXI_awready = 0; M_AXI_wready = 0; M_AXI_arready = 0;
                M_AXI_bvalid = 0; M_AXI_rvalid = 0;
            end else begin
                if (aw_fire) begin aw_got = 1; aw_cnt = 0; end
                if (w_fire)  begin w_got = 1;  w_cnt = 0;  end
                if (b_fire)  begin b_pend = 0; M_AXI_bvalid = 0; end
                if (r_fire)  begin r_pend = 0; M_AXI_rvalid = 0; end
                if (ar_fire) begin
                    idx = ar_a >> 2;
                    r_d = (idx < 256) ? slave_mem[idx] : 32'h0;
                    r_r = (idx < 256) ? 2'b00 : 2'b10;
                    r_pend = 1; r_cnt = 0; ar_cnt = 0;
                end
                if (aw_got && w_got) begin
                    idx = aw_a >> 2;
                    if (idx < 256) begin
                        for (int b = 0; b < 4; b++)
                            if (w_s[b]) slave_mem[idx][b*8 +: 8] = w_d[b*8 +: 8];
                        b_r = 2'b00;
                    end else begin
                        b_r = 2'b10;
                    end
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end
                M_AXI_awready = 0;
                if (M_AXI_awvalid && !aw_got) begin
                    if (aw_cnt >= aw_delay) M_AXI_awready = 1; else aw_cnt++;
                end
                M_AXI_wready = 0;
                if (M_AXI_wvalid && !w_got) begin
                    if (w_cnt >= w_delay) M_AXI_wready = 1; else w_cnt++;
                end
                M_AXI_arready = 0;
                if (M_AXI_arvalid && !r_pend) begin
                    if (ar_cnt >= ar_delay) M_AXI_arready = 1; else ar_cnt++;
                end
                if (b_pend && !M_AXI_bvalid && !b_never) begin
                    if (b_cnt >= b_delay) begin M_AXI_bvalid = 1; M_AXI_bresp = b_r; end
                    else b_cnt++;
                end
                if (r_pend && !M_AXI_rvalid) begin
                    if (r_cnt >= r_delay) begin
                        M_AXI_rvalid = 1; M_AXI_rdata = r_d; M_AXI_rresp = r_r; M_AXI_rlast = 1;
                    end else r_cnt++;
                end
                aw_fire = M_AXI_awvalid && M_AXI_awready;
                if (aw_fire) begin aw_a = M_AXI_awaddr; last_awaddr = M_AXI_awaddr; end
                w_fire = M_AXI_wvalid && M_AXI_wready;
                if (w_fire) begin w_d = M_AXI_wdata; w_s = M_AXI_wstrb; end
                ar_fire = M_AXI_arvalid && M_AXI_arready;
                if (ar_fire) ar_a = M_AXI_araddr;
                b_fire = M_AXI_bvalid && M_AXI_bready;
                r_fire = M_AXI_rvalid && M_AXI_rready;
            end
        end
    end

    // ---------------- reference model: plain word array ----------------
    logic [31:0] ref_mem [256];

    task automatic model(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [31:0] exp_rdata,
                         output logic [1:0] exp_resp);
        int unsigned word = addr / 4;
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        exp_rdata = 32'h0;
        if (word >= 256) begin
            exp_resp = 2'b10;
        end else begin
            exp_resp = 2'b00;
            if (wr) ref_mem[word] = (ref_mem[word] & ~mask) | (data & mask);
            else    exp_rdata = ref_mem[word];
        end
    endtask

    // ---------------- command / response helpers (called at a negedge) ----------------
    task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output bit ok);
        int n = 0;
        ok = 0;
        while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
            return;
        end
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(negedge ACLK);
        cmd_valid = 0;
        ok = 1;
    endtask

    task automatic finish_txn(input string name, input int hold,
                              input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
        int n = 0;
        while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s rsp_wait: rsp_valid=%b want 1", name, rsp_valid);
            return;
        end
        total++;
        if (rsp_rdata !== exp_rdata || rsp_resp !== exp_resp || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s rsp: rdata=%h resp=%b cmd_ready=%b want rdata=%h resp=%b cmd_ready=0",
                     name, rsp_rdata, rsp_resp, cmd_ready, exp_rdata, exp_resp);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_resp !== exp_resp ||
                cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s hold%0d: valid=%b rdata=%h resp=%b cmd_ready=%b want 1 %h %b 0",
                         name, i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready, exp_rdata, exp_resp);
            end
        end
        rsp_ready = 1;
        @(negedge ACLK);
        rsp_ready = 0;
        total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s after_hs: cmd_ready=%b rsp_valid=%b want 1 0", name, cmd_ready, rsp_valid);
        end
    endtask

    task automatic txn(input string name, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input int hold);
        logic [31:0] er;
        logic [1:0]  ep;
        bit ok;
        model(wr, addr, data, strb, er, ep);
        issue_cmd(wr, addr, data, strb, ok);
        if (ok) finish_txn(name, hold, er, ep);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ARESETN = 0;
        repeat (3) @(negedge ACLK);
        total++;
        if ({cmd_ready, M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready, M_AXI_rready,
             rsp_valid, err_timeout} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_handshake: got %b want 10000000",
                     {cmd_ready, M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready,
                      M_AXI_rready, rsp_valid, err_timeout});
        end
        total++;
        if ({rsp_rdata, rsp_resp, M_AXI_awaddr, M_AXI_araddr, M_AXI_wdata, M_AXI_wstrb} !== '0) begin
            bad++;
            $display("FAIL reset_payload: rdata=%h resp=%b awaddr=%h araddr=%h wdata=%h wstrb=%h want 0",
                     rsp_rdata, rsp_resp, M_AXI_awaddr, M_AXI_araddr, M_AXI_wdata, M_AXI_wstrb);
        end
        total++;
        if ({M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awlock, M_AXI_awcache, M_AXI_awprot,
             M_AXI_awregion, M_AXI_awqos, M_AXI_arlen, M_AXI_arsize, M_AXI_arburst, M_AXI_arlock,
             M_AXI_arcache, M_AXI_arprot, M_AXI_arregion, M_AXI_arqos, M_AXI_wlast} !==
            {8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0,
             8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_constants: awlen=%h awsize=%b awburst=%b arsize=%b arburst=%b wlast=%b",
                     M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_arsize, M_AXI_arburst, M_AXI_wlast);
        end
        ARESETN = 1;
        @(negedge ACLK);
    endtask

    task automatic test_basic_write_read();
        logic [31:0] er;
        logic [1:0]  ep;
        bit ok;
        model(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, er, ep);
        issue_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ok);
        total++;
        if ({M_AXI_awvalid, M_AXI_wvalid, cmd_ready} !== 3'b110 || M_AXI_awaddr !== 32'h10 ||
            M_AXI_wdata !== 32'hDEADBEEF || M_AXI_wstrb !== 4'hF) begin
            bad++;
            $display("FAIL wr_issue: aw/w/cmd_ready=%b awaddr=%h wdata=%h wstrb=%h want 110 10 deadbeef f",
                     {M_AXI_awvalid, M_AXI_wvalid, cmd_ready}, M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb);
        end
        if (ok) finish_txn("basic_write", 0, er, ep);
        model(1'b0, 32'h10, 32'h0, 4'h0, er, ep);
        issue_cmd(1'b0, 32'h10, 32'h0, 4'h0, ok);
        total++;
        if (M_AXI_arvalid !== 1'b1 || M_AXI_araddr !== 32'h10) begin
            bad++;
            $display("FAIL rd_issue: arvalid=%b araddr=%h want 1 10", M_AXI_arvalid, M_AXI_araddr);
        end
        if (ok) finish_txn("basic_read", 0, er, ep);
    endtask

    task automatic test_aw_stall();
        logic [31:0] er;
        logic [1:0]  ep;
        bit ok;
        aw_delay = 3;
        model(1'b1, 32'h13, 32'h12345678, 4'hF, er, ep);
        issue_cmd(1'b1, 32'h13, 32'h12345678, 4'hF, ok);
        total++;
        if ({M_AXI_awvalid, M_AXI_wvalid} !== 2'b11 || M_AXI_awaddr !== 32'h10) begin
            bad++;
            $display("FAIL stall_issue: aw/w=%b awaddr=%h want 11 10", {M_AXI_awvalid, M_AXI_wvalid}, M_AXI_awaddr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            total++;
            if ({M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready} !== 3'b100) begin
                bad++;
                $display("FAIL stall_wait%0d: aw/w/bready=%b want 100", i, {M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready});
            end
        end
        @(negedge ACLK);
        total++;
        if ({M_AXI_awvalid, M_AXI_bready} !== 2'b01 || last_awaddr !== 32'h10) begin
            bad++;
            $display("FAIL stall_done: aw/bready=%b slave_awaddr=%h want 01 10",
                     {M_AXI_awvalid, M_AXI_bready}, last_awaddr);
        end
        if (ok) finish_txn("aw_stall", 0, er, ep);
        aw_delay = 0;
    endtask

    task automatic test_out_of_range();
        txn("oor_read", 1'b0, 32'h400, 32'h0, 4'h0, 0);
    endtask

    task automatic test_rsp_hold();
        r_delay = 2;
        txn("rsp_hold", 1'b0, 32'h10, 32'h0, 4'h0, 5);
        r_delay = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] er;
        logic [1:0]  ep;
        bit ok;
        int n = 0;
        b_delay = 10;
        model(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, er, ep);
        issue_cmd(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, ok);
        while (M_AXI_bready !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
        total++;
        if (M_AXI_bready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_bready: got %b want 1", M_AXI_bready);
        end
        @(negedge ACLK);
        ARESETN = 0;
        @(negedge ACLK);
        total++;
        if ({cmd_ready, M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready, M_AXI_rready,
             rsp_valid} !== 7'b1000000) begin
            bad++;
            $display("FAIL midrst_state: got %b want 1000000",
                     {cmd_ready, M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready,
                      M_AXI_rready, rsp_valid});
        end
        @(negedge ACLK);
        ARESETN = 1;
        b_delay = 0;
        @(negedge ACLK);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_norsp: rsp_valid=%b want 0", rsp_valid);
        end
        txn("midrst_read", 1'b0, 32'h20, 32'h0, 4'h0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int unsigned word;
            logic [31:0] addr;
            word = ($urandom_range(0, 9) == 0) ? $urandom_range(256, 300) : $urandom_range(0, 15);
            addr = word * 4 + $urandom_range(0, 3);
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            txn($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), addr, $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) @(negedge ACLK);
        end
        {aw_delay, w_delay, b_delay, ar_delay, r_delay} = '0;
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n = 0;
        int waited = 0;
        b_never = 1;
        issue_cmd(1'b1, 32'h30, 32'h55AA55AA, 4'hF, ok);
        while (!rsp_valid && n < 50) begin
            if (M_AXI_bready) waited++;
            @(negedge ACLK);
            n++;
        end
        total++;
        if (waited != 8) begin
            bad++;
            $display("FAIL timeout_cycles: got %0d want 8", waited);
        end
        if (ok) finish_txn("timeout", 0, 32'h0, 2'b11);
        total++;
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: err_timeout=%b want 1", err_timeout);
        end
        ARESETN = 0;
        b_never = 0;
        repeat (2) @(negedge ACLK);
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: err_timeout=%b want 0", err_timeout);
        end
        ARESETN = 1;
        @(negedge ACLK);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        @(negedge ACLK);
        test_reset();
        test_basic_write_read();
        test_aw_stall();
        test_out_of_range();
        test_rsp_hold();
        test_reset_mid();
        test_random();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_simple_master.md
Name: axi4_simple_master

Overview:
- Single-beat AXI4 master bridge between the CPU ALU's simple command/response port and the interconnect feeding Simple_Memory_Slave.
- Converts one command (read or write) into one AXI4 transaction (len 0, 32-bit, INCR).
- Returns read data and the response code on a valid/ready response port.
- Exactly one transaction is outstanding at any time.

Parameters:
- ADDR_WIDTH, 32, AXI and command address width.
- DATA_WIDTH, 32, data width; must be 32.
- TIMEOUT_CYCLES, 255, response-phase watchdog limit; used only with the optional feature.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset (see Behaviour)
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  byte enables
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  AXI response code
- M_AXI_aw{addr,len,size,burst,lock,cache,prot,region,qos,valid}  out  AXI widths  write address channel
- M_AXI_awready  in  1
- M_AXI_w{data,strb,last,valid}  out  AXI widths  write data channel
- M_AXI_wready  in  1
- M_AXI_bresp  in  2
- M_AXI_bvalid  in  1
- M_AXI_bready  out  1
- M_AXI_ar{addr,len,size,burst,lock,cache,prot,region,qos,valid}  out  AXI widths  read address channel
- M_AXI_arready  in  1
- M_AXI_r{data,resp,last,valid}  in  AXI widths  read data channel
- M_AXI_rready  out  1

Behaviour:
- Reset: reset ARESETN, synchronous, active-low; clock ACLK.
  - In reset: state IDLE; all valid/ready outputs 0 except cmd_ready = 1.
  - In reset: rsp_rdata = 0, rsp_resp = 0, addr/data/strb outputs 0.
  - Reset mid-transaction abandons the transaction; no response is issued.
- Constant outputs: len = 0, size = 3'b010, burst = 2'b01, lock/cache/prot/region/qos = 0, wlast = 1.
- Address handling: awaddr/araddr = latched cmd_addr with bits [1:0] forced to 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP. All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch the command, drop cmd_ready, and go to WR_REQ or RD_REQ.
  - awvalid/wvalid/arvalid rise the next cycle (1-cycle latency).
- WR_REQ:
  - awvalid and wvalid are asserted together; each drops independently on its own handshake.
  - The state is left only when both handshakes have occurred, including both in the same cycle or W before AW.
  - Valids never drop before their handshake; the payload stays stable.
  - Next state: WR_RESP, with bready = 1.
- WR_RESP:
  - On bvalid, capture bresp into rsp_resp, set rsp_rdata = 0, drop bready, go to RESP.
- RD_REQ:
  - arvalid held until arready, then go to RD_DATA with rready = 1.
- RD_DATA:
  - On rvalid, capture rdata and rresp, drop rready, go to RESP.
  - rlast is ignored.
- RESP:
  - rsp_valid = 1, payload stable until rsp_ready.
  - Then go to IDLE with cmd_ready = 1 the following cycle.
  - Back-to-back commands therefore need at least one idle cycle after the response handshake.
- Unexpected bvalid/rvalid outside WR_RESP/RD_DATA are not acknowledged.

Optional Feature:
- Macro AXI_MASTER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter runs in WR_RESP and RD_DATA.
  - If TIMEOUT_CYCLES cycles elapse without the response handshake: drop bready/rready, go to RESP with rsp_resp = 2'b11, rsp_rdata = 0.
  - Sticky output err_timeout is set; only reset clears it.
  - The counter clears on entering each response state.
- Undefined: no counter and no err_timeout port; the block waits indefinitely.

Decomposition:
- Package axi4_master_pkg holds:
  - the state encoding;
  - AXI constants: SIZE_4B, BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR.
- The FSM stays in one module.
- The watchdog is the natural sub-module: axi4_resp_watchdog (start, clear, expired).

Test Plan:
- Write 0xDEADBEEF to 0x10, strb 0xF, slave with immediate ready:
  - awvalid and wvalid are high 1 cycle after cmd accept;
  - rsp_resp = 00.
  - Read 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_resp = 00.
- Slave holds awready low 3 cycles while wready is immediate:
  - wvalid drops after its handshake, awvalid stays high;
  - WR_RESP is entered only after AW completes;
  - cmd_addr 0x13 appears as awaddr 0x10.
- Read of word address >= 256 (0x400) -> rsp_resp = 2'b10, rsp_rdata = 0.
- rsp_ready held low 5 cycles:
  - rsp_valid and payload stay stable;
  - cmd_ready stays 0 until one cycle after the response handshake.
- ARESETN low in WR_RESP:
  - next cycle all valids = 0, cmd_ready = 1, no rsp_valid;
  - a following read completes normally.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never asserts bvalid:
  - after 8 cycles rsp_resp = 11 and err_timeout = 1.
